// File: rtl/axi_sram_slave.sv
// ----------------------------------------------------------------------------
// axi_sram_slave
//
// AXI4 slave memory responder sitting behind the instruction-fetch and
// load/store masters. Serves INCR read bursts (32-bit beats, up to 256 beats)
// and single-beat writes with byte strobes from an internal word array, after
// fixed, parameterised latencies. Out-of-range addresses answer DECERR and
// unsupported beat sizes answer SLVERR.
//
// Handshake rule (all five channels): a transfer happens on the rising edge
// of clk where both VALID and READY are high; a source holds VALID and its
// payload stable until that edge and never withdraws VALID early.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   axi_ar*                 read address channel (addr, len, size)
//   axi_r*                  read data channel (data, resp, last)
//   axi_aw*                 write address channel
//   axi_w*                  write data channel (data, strobes)
//   axi_b*                  write response channel
//   dbg_rd_state_o          current read FSM state (R_IDLE/R_LAT/R_DATA)
//   dbg_wr_state_o          current write FSM state (W_IDLE/W_LAT/W_RESP)
// ----------------------------------------------------------------------------
module axi_sram_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          RD_LAT      = 2,
    parameter int          WR_LAT      = 1
) (
    input  logic        clk,
    input  logic        reset,
    // read address
    input  logic [31:0] axi_araddr,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [7:0]  axi_arlen,
    input  logic [2:0]  axi_arsize,
    // read data
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic        axi_rlast,
    // write address
    input  logic [31:0] axi_awaddr,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    // write data
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    // write response
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    // FSM observability
    output logic [1:0]  dbg_rd_state_o,
    output logic [1:0]  dbg_wr_state_o
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_LAT, W_RESP} wr_state_e;

    // Unsigned offset: addresses below ADDR_BASE wrap to huge values and so
    // also fall outside the window.
    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return off < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return off[IDX_W+1:2];
    endfunction

    logic [31:0] mem_q [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    rd_state_e   rd_state_q, rd_state_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic [7:0]  rd_len_q, rd_len_d;
    logic [7:0]  rd_beat_q, rd_beat_d;
    logic        rd_size_err_q, rd_size_err_d;
    logic [3:0]  rd_cnt_q, rd_cnt_d;
    logic        rd_hold_q, rd_hold_d;
    logic [31:0] rd_hold_data_q, rd_hold_data_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q     <= R_IDLE;
            rd_addr_q      <= '0;
            rd_len_q       <= '0;
            rd_beat_q      <= '0;
            rd_size_err_q  <= 1'b0;
            rd_cnt_q       <= '0;
            rd_hold_q      <= 1'b0;
            rd_hold_data_q <= '0;
        end else begin
            rd_state_q     <= rd_state_d;
            rd_addr_q      <= rd_addr_d;
            rd_len_q       <= rd_len_d;
            rd_beat_q      <= rd_beat_d;
            rd_size_err_q  <= rd_size_err_d;
            rd_cnt_q       <= rd_cnt_d;
            rd_hold_q      <= rd_hold_d;
            rd_hold_data_q <= rd_hold_data_d;
        end
    end

    always_comb begin
        rd_state_d     = rd_state_q;
        rd_addr_d      = rd_addr_q;
        rd_len_d       = rd_len_q;
        rd_beat_d      = rd_beat_q;
        rd_size_err_d  = rd_size_err_q;
        rd_cnt_d       = rd_cnt_q;
        rd_hold_d      = rd_hold_q;
        rd_hold_data_d = rd_hold_data_q;

        axi_arready = (rd_state_q == R_IDLE);
        axi_rvalid  = (rd_state_q == R_DATA);
        axi_rlast   = 1'b0;
        axi_rresp   = RESP_OKAY;
        axi_rdata   = '0;

        if (rd_state_q == R_DATA) begin
            axi_rlast = (rd_beat_q == rd_len_q);
            // Range is checked per beat so a burst running off the top of
            // the array turns to DECERR from that beat onward.
            if (!in_range(rd_addr_q)) begin
                axi_rresp = RESP_DECERR;
            end else if (rd_size_err_q) begin
                axi_rresp = RESP_SLVERR;
            end else begin
                // The array is read combinationally in the first cycle a beat
                // is shown, then frozen while the master stalls, so a write
                // committing during a stall cannot change a presented beat.
                axi_rdata = rd_hold_q ? rd_hold_data_q : mem_q[word_idx(rd_addr_q)];
            end
        end

        case (rd_state_q)
            R_IDLE: begin
                if (axi_arvalid) begin
                    rd_addr_d     = axi_araddr;
                    rd_len_d      = axi_arlen;
                    rd_beat_d     = '0;
                    rd_size_err_d = (axi_arsize != 3'b010);
                    rd_cnt_d      = '0;
                    rd_hold_d     = 1'b0;
                    rd_state_d    = (RD_LAT > 0) ? R_LAT : R_DATA;
                end
            end
            R_LAT: begin
                rd_cnt_d = rd_cnt_q + 4'd1;
                if (rd_cnt_q == 4'(RD_LAT - 1)) begin
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (axi_rready) begin
                    rd_hold_d = 1'b0;
                    if (axi_rlast) begin
                        rd_state_d = R_IDLE;
                    end else begin
                        rd_addr_d = rd_addr_q + 32'd4;
                        rd_beat_d = rd_beat_q + 8'd1;
                    end
                end else begin
                    rd_hold_d      = 1'b1;
                    rd_hold_data_d = axi_rdata;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    assign dbg_rd_state_o = rd_state_q;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    wr_state_e   wr_state_q, wr_state_d;
    logic        aw_held_q, aw_held_d;
    logic        w_held_q, w_held_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [3:0]  wr_strb_q, wr_strb_d;
    logic [3:0]  wr_cnt_q, wr_cnt_d;

    logic        aw_take, w_take, wr_commit;
    logic [31:0] eff_addr, eff_data;
    logic [3:0]  eff_strb;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
            wr_cnt_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_strb_q  <= wr_strb_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_strb_d  = wr_strb_q;
        wr_cnt_d   = wr_cnt_q;
        wr_commit  = 1'b0;

        axi_awready = (wr_state_q == W_IDLE) && !aw_held_q;
        axi_wready  = (wr_state_q == W_IDLE) && !w_held_q;
        axi_bvalid  = (wr_state_q == W_RESP);
        axi_bresp   = (axi_bvalid && !in_range(wr_addr_q)) ? RESP_DECERR : RESP_OKAY;

        aw_take = axi_awvalid && axi_awready;
        w_take  = axi_wvalid && axi_wready;

        // With WR_LAT=0 the commit happens in the capture cycle, before the
        // holding registers are loaded, so the live channel values are used.
        eff_addr = aw_held_q ? wr_addr_q : axi_awaddr;
        eff_data = w_held_q  ? wr_data_q : axi_wdata;
        eff_strb = w_held_q  ? wr_strb_q : axi_wstrb;

        case (wr_state_q)
            W_IDLE: begin
                if (aw_take) begin
                    aw_held_d = 1'b1;
                    wr_addr_d = axi_awaddr;
                end
                if (w_take) begin
                    w_held_d  = 1'b1;
                    wr_data_d = axi_wdata;
                    wr_strb_d = axi_wstrb;
                end
                if ((aw_held_q || aw_take) && (w_held_q || w_take)) begin
                    wr_cnt_d = '0;
                    if (WR_LAT > 0) begin
                        wr_state_d = W_LAT;
                    end else begin
                        wr_commit  = 1'b1;
                        wr_state_d = W_RESP;
                    end
                end
            end
            W_LAT: begin
                wr_cnt_d = wr_cnt_q + 4'd1;
                if (wr_cnt_q == 4'(WR_LAT - 1)) begin
                    wr_commit  = 1'b1;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (axi_bready) begin
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign dbg_wr_state_o = wr_state_q;

    // Memory array: no reset. A reset in the commit cycle drops the write.
    always_ff @(posedge clk) begin
        if (wr_commit && !reset && in_range(eff_addr)) begin
            for (int b = 0; b < 4; b++) begin
                if (eff_strb[b]) begin
                    mem_q[word_idx(eff_addr)][8*b +: 8] <= eff_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// ----------------------------------------------------------------------------
// tb_axi_sram_slave
//
// Directed bench for axi_sram_slave. Driver tasks issue AXI reads/writes and
// push hand-computed responses into expected queues; a monitor pops and
// compares every R and B handshake, and checks R payload stability across
// stalls.
// ----------------------------------------------------------------------------
module tb_axi_sram_slave;

    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;

    logic        clk;
    logic        reset;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic        axi_rlast;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [1:0]  dbg_rd_state;
    logic [1:0]  dbg_wr_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic abort_rd = 1'b0;

    logic [34:0] exp_r_q[$];   // {last, resp, data}
    logic [1:0]  exp_b_q[$];

    axi_sram_slave #(
        .ADDR_BASE  (32'h8000_0000),
        .DEPTH_WORDS(4096),
        .RD_LAT     (RD_LAT),
        .WR_LAT     (WR_LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .axi_araddr    (axi_araddr),
        .axi_arvalid   (axi_arvalid),
        .axi_arready   (axi_arready),
        .axi_arlen     (axi_arlen),
        .axi_arsize    (axi_arsize),
        .axi_rdata     (axi_rdata),
        .axi_rresp     (axi_rresp),
        .axi_rvalid    (axi_rvalid),
        .axi_rready    (axi_rready),
        .axi_rlast     (axi_rlast),
        .axi_awaddr    (axi_awaddr),
        .axi_awvalid   (axi_awvalid),
        .axi_awready   (axi_awready),
        .axi_wdata     (axi_wdata),
        .axi_wstrb     (axi_wstrb),
        .axi_wvalid    (axi_wvalid),
        .axi_wready    (axi_wready),
        .axi_bresp     (axi_bresp),
        .axi_bvalid    (axi_bvalid),
        .axi_bready    (axi_bready),
        .dbg_rd_state_o(dbg_rd_state),
        .dbg_wr_state_o(dbg_wr_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_r(input logic [31:0] d, input logic [1:0] resp, input logic last);
        exp_r_q.push_back({last, resp, d});
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic        stall_pend;
        logic [34:0] stall_val;
        logic [34:0] exp_r;
        stall_pend = 1'b0;
        stall_val  = '0;
        forever begin
            @(negedge clk);
            if (stall_pend) begin
                if (axi_rvalid)
                    check("r_stable", {axi_rlast, axi_rresp, axi_rdata}, stall_val);
                else if (!abort_rd)
                    check("r_valid_held", 0, 1);
                stall_pend = 1'b0;
            end
            if (axi_rvalid && !axi_rready) begin
                stall_pend = 1'b1;
                stall_val  = {axi_rlast, axi_rresp, axi_rdata};
            end
            if (axi_rvalid && axi_rready) begin
                if (exp_r_q.size() == 0) begin
                    check("r_unexpected", {axi_rlast, axi_rresp, axi_rdata}, 64'hx);
                end else begin
                    exp_r = exp_r_q.pop_front();
                    check("r_beat", {axi_rlast, axi_rresp, axi_rdata}, exp_r);
                end
            end
            if (axi_bvalid && axi_bready) begin
                if (exp_b_q.size() == 0)
                    check("b_unexpected", axi_bresp, 64'hx);
                else
                    check("b_resp", axi_bresp, exp_b_q.pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    // Read burst; pat[i] is rready for the i-th cycle in which rvalid is high
    // (1 once the pattern runs out). Also checks first-beat latency.
    task automatic rd(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                      input logic [15:0] pat, input int npat);
        int   cyc, pi, beats, n;
        logic seen, got_ar;
        n = int'(len) + 1;
        @(posedge clk); #1;
        axi_araddr = addr; axi_arlen = len; axi_arsize = size;
        axi_arvalid = 1'b1; axi_rready = 1'b0;
        got_ar = 1'b0;
        for (int i = 0; i < 20 && !got_ar; i++) begin
            @(negedge clk);
            if (axi_arready) got_ar = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("ar_accept", got_ar, 1);
        @(posedge clk); #1;
        axi_arvalid = 1'b0;
        cyc = 1; pi = 0; beats = 0; seen = 1'b0;
        while (beats < n && cyc < 600) begin
            if (axi_rvalid) begin
                axi_rready = (pi < npat) ? pat[pi] : 1'b1;
                pi++;
            end else begin
                axi_rready = 1'b0;
            end
            @(negedge clk);
            if (axi_rvalid && !seen) begin
                seen = 1'b1;
                check("r_first_latency", cyc, RD_LAT + 1);
            end
            if (axi_rvalid && axi_rready) beats++;
            @(posedge clk); #1;
            cyc++;
        end
        axi_rready = 1'b0;
        check("r_burst_done", beats, n);
    endtask

    // Write; W is presented w_lead cycles before AW (0 = together).
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input int w_lead, input logic [1:0] bresp);
        int   cyc;
        logic aw_done, w_done, aw_hs, w_hs, b_done;
        exp_b_q.push_back(bresp);
        @(posedge clk); #1;
        axi_awaddr = addr; axi_wdata = data; axi_wstrb = strb;
        axi_wvalid = 1'b1; axi_awvalid = (w_lead == 0);
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            @(negedge clk);
            if (w_done && !aw_done) check("wready_drop", axi_wready, 0);
            aw_hs = axi_awvalid && axi_awready;
            w_hs  = axi_wvalid && axi_wready;
            @(posedge clk); #1;
            cyc++;
            if (aw_hs) begin axi_awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin axi_wvalid  = 1'b0; w_done  = 1'b1; end
            if (!aw_done && cyc >= w_lead) axi_awvalid = 1'b1;
        end
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        check("w_accept", {aw_done, w_done}, 2'b11);
        b_done = 1'b0;
        for (int i = 0; i < 20 && !b_done; i++) begin
            @(negedge clk);
            if (axi_bvalid) b_done = 1'b1;
            @(posedge clk); #1;
        end
        check("b_seen", b_done, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        reset = 1'b1;
        axi_araddr = '0; axi_arvalid = 1'b0; axi_arlen = '0; axi_arsize = 3'b010;
        axi_rready = 1'b0;
        axi_awaddr = '0; axi_awvalid = 1'b0; axi_wdata = '0; axi_wstrb = '0;
        axi_wvalid = 1'b0; axi_bready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_arready", axi_arready, 1);
        check("rst_awready", axi_awready, 1);
        check("rst_wready",  axi_wready,  1);
        check("rst_rvalid",  axi_rvalid,  0);
        check("rst_bvalid",  axi_bvalid,  0);
        check("rst_rdata_rresp_rlast", {axi_rlast, axi_rresp, axi_rdata}, 35'h0);
        check("rst_bresp",   axi_bresp,   0);

        // preload
        wr(32'h8000_0000, 32'h0BAD_F00D, 4'hF, 0, 2'b00);
        wr(32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 0, 2'b00);
        wr(32'h8000_0008, 32'hFFFF_FFFF, 4'hF, 0, 2'b00);
        wr(32'h8000_000C, 32'h1234_5678, 4'hF, 0, 2'b00);
        wr(32'h8000_0010, 32'h4444_0004, 4'hF, 0, 2'b00);
        wr(32'h8000_0014, 32'h5555_0005, 4'hF, 0, 2'b00);
        wr(32'h8000_0018, 32'h6666_0006, 4'hF, 0, 2'b00);
        wr(32'h8000_001C, 32'h7777_0007, 4'hF, 0, 2'b00);
        wr(32'h8000_3FFC, 32'hCAFE_0FFF, 4'hF, 0, 2'b00);
        wr(32'h8000_0080, 32'hA5A5_5A5A, 4'hF, 0, 2'b00);

        // single read, latency and payload
        push_r(32'hDEAD_BEEF, 2'b00, 1'b1);
        rd(32'h8000_0004, 8'd0, 3'b010, 16'h0, 0);

        // low address bits ignored
        push_r(32'hDEAD_BEEF, 2'b00, 1'b1);
        rd(32'h8000_0006, 8'd0, 3'b010, 16'h0, 0);

        // burst with stalls: rready 1,0,1,1,0,1
        push_r(32'h4444_0004, 2'b00, 1'b0);
        push_r(32'h5555_0005, 2'b00, 1'b0);
        push_r(32'h6666_0006, 2'b00, 1'b0);
        push_r(32'h7777_0007, 2'b00, 1'b1);
        rd(32'h8000_0010, 8'd3, 3'b010, 16'b10_1101, 6);

        // strobed write, W leading AW by 3 cycles
        wr(32'h8000_0008, 32'h1122_3344, 4'b0101, 3, 2'b00);
        push_r(32'hFF22_FF44, 2'b00, 1'b1);
        rd(32'h8000_0008, 8'd0, 3'b010, 16'h0, 0);

        // out-of-range read and write
        push_r(32'h0, 2'b11, 1'b0);
        push_r(32'h0, 2'b11, 1'b1);
        rd(32'h0000_0000, 8'd1, 3'b010, 16'h0, 0);
        wr(32'h9000_0000, 32'hFFFF_FFFF, 4'hF, 0, 2'b11);
        push_r(32'h0BAD_F00D, 2'b00, 1'b1);
        rd(32'h8000_0000, 8'd0, 3'b010, 16'h0, 0);

        // unsupported size
        push_r(32'h0, 2'b10, 1'b1);
        rd(32'h8000_0004, 8'd0, 3'b001, 16'h0, 0);

        // burst crossing the top of the array
        push_r(32'hCAFE_0FFF, 2'b00, 1'b0);
        push_r(32'h0, 2'b11, 1'b1);
        rd(32'h8000_3FFC, 8'd1, 3'b010, 16'h0, 0);

        // zero strobes: OKAY, no change
        wr(32'h8000_000C, 32'h0, 4'h0, 0, 2'b00);
        push_r(32'h1234_5678, 2'b00, 1'b1);
        rd(32'h8000_000C, 8'd0, 3'b010, 16'h0, 0);

        // reset during beat 2 of an 8-beat burst with a write in W_LAT
        push_r(32'h4444_0004, 2'b00, 1'b0);
        push_r(32'h5555_0005, 2'b00, 1'b0);
        @(posedge clk); #1;
        axi_araddr = 32'h8000_0010; axi_arlen = 8'd7; axi_arsize = 3'b010;
        axi_arvalid = 1'b1; axi_rready = 1'b1;
        @(posedge clk); #1; axi_arvalid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;                                  // beat 0
        axi_awaddr = 32'h8000_0080; axi_wdata = 32'h0; axi_wstrb = 4'hF;
        @(posedge clk); #1;                                  // beat 1, AW+W captured
        axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        // The capture must land in the same cycle as beat 1; AW/W were
        // raised after the beat-0 edge so they handshake at the beat-1 edge.
        @(posedge clk); #1;                                  // beat 2 presented
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        axi_rready = 1'b0; abort_rd = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check("rt_rvalid_before", axi_rvalid, 1);
        check("rt_wr_in_lat", dbg_wr_state, 2'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rt_rvalid", axi_rvalid, 0);
        check("rt_bvalid", axi_bvalid, 0);
        check("rt_arready", axi_arready, 1);
        check("rt_awready", axi_awready, 1);
        check("rt_wready", axi_wready, 1);
        check("rt_r_queue_drained", exp_r_q.size(), 0);
        @(posedge clk); #1;
        abort_rd = 1'b0;
        push_r(32'hA5A5_5A5A, 2'b00, 1'b1);
        rd(32'h8000_0080, 8'd0, 3'b010, 16'h0, 0);

        repeat (3) @(posedge clk);
        check("end_r_queue_empty", exp_r_q.size(), 0);
        check("end_b_queue_empty", exp_b_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4 slave memory responder; it is the target end of the instruction-fetch and load/store AXI masters.
- Accepts read bursts (INCR, arlen up to 255, 32-bit beats) and single-beat writes with byte strobes.
- Serves data from an internal word array after a fixed, parameterised latency.
- Flags out-of-range or unsupported-size accesses with error responses; this drives the masters' Access_Fault path.

Parameters:
- ADDR_BASE, 32'h8000_0000, byte address of word 0.
- DEPTH_WORDS, 4096, number of 32-bit words; must be a power of two.
- RD_LAT, 2, idle cycles between AR handshake and first R beat; range 0..15.
- WR_LAT, 1, idle cycles between capture of both AW and W and B assertion; range 0..15.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- axi_araddr  input  32  read start byte address
- axi_arvalid  input  1  read address valid
- axi_arready  output  1  read address ready
- axi_arlen  input  8  beats minus one
- axi_arsize  input  3  log2 bytes per beat; only 3'b010 supported
- axi_rdata  output  32  read data
- axi_rresp  output  2  00 OKAY, 10 SLVERR, 11 DECERR
- axi_rvalid  output  1  read data valid
- axi_rready  input  1  read data ready
- axi_rlast  output  1  final beat of burst
- axi_awaddr  input  32  write byte address
- axi_awvalid  input  1  write address valid
- axi_awready  output  1  write address ready
- axi_wdata  input  32  write data
- axi_wstrb  input  4  byte enables
- axi_wvalid  input  1  write data valid
- axi_wready  output  1  write data ready
- axi_bresp  output  2  write response
- axi_bvalid  output  1  write response valid
- axi_bready  input  1  write response ready

Behaviour:
- Reset values: arready=1, rvalid=0, rlast=0, rresp=00, rdata=0, awready=1, wready=1, bvalid=0, bresp=00; both FSMs go idle. Memory contents are not cleared.
- Reset asserted mid-burst or mid-write aborts the transaction. Any pending write that has not reached commit is dropped.
- Read FSM states: R_IDLE, R_LAT, R_DATA.
  - R_IDLE: arready=1. On arvalid&arready, latch addr, len and size; clear the beat counter; arready goes 0 next cycle. Go to R_LAT if RD_LAT>0, else R_DATA.
  - R_LAT: count RD_LAT cycles, then go to R_DATA.
  - R_DATA: rvalid=1. rdata = mem[(addr-ADDR_BASE)>>2 & (DEPTH_WORDS-1)], sampled when the beat is presented. rlast=1 when beat==len.
  - While rvalid=1 and rready=0, rdata, rresp and rlast are held stable.
  - On rvalid&rready: if not last, addr+=4 and beat+=1, and the next beat appears in the following cycle with no inter-beat latency. If last, go to R_IDLE with rvalid=0 and arready=1 in the following cycle.
- Read errors:
  - Start addr outside [ADDR_BASE, ADDR_BASE+4*DEPTH_WORDS) gives rresp=11 on every beat, with rdata=0.
  - arsize!=3'b010 gives rresp=10 on every beat, with rdata=0.
  - The burst length is still honoured; rlast still appears on beat len.
  - A burst whose incremented address crosses the top of the array reports 11 from the first out-of-range beat onward.
- Write FSM states: W_IDLE, W_LAT, W_RESP.
  - W_IDLE: AW and W are captured independently. awready drops after AW is captured; wready drops after W is captured. When both are held (same cycle or different cycles), go to W_LAT.
  - W_LAT: count WR_LAT cycles, then commit mem bytes per wstrb and go to W_RESP. Commit occurs in the cycle of the W_LAT exit, or the capture cycle when WR_LAT=0.
  - W_RESP: bvalid=1 until bready. Then return to W_IDLE, with awready=1 and wready=1 next cycle.
- Write errors: out-of-range address gives bresp=11 and no memory change. wstrb=0 gives bresp=00 and no change.
- Read and write FSMs are fully independent and may be active concurrently.
- A read beat presented in the same cycle as a write commit to the same word returns the old data. A beat presented a cycle later returns the new data.
- Address bits [1:0] are ignored; the access is word aligned.

Test Plan:
- Reset, then a single read of 0x8000_0004 (arlen=0) with preloaded mem[1]=32'hDEAD_BEEF -> rvalid rises exactly RD_LAT+1 cycles after the AR handshake, with rdata=DEAD_BEEF, rlast=1, rresp=00.
- Burst read at 0x8000_0010, arlen=3, rready toggling 1,0,1,1,0,1 -> 4 beats of mem[4..7] in order, each held stable while stalled, rlast only on the 4th beat.
- Write to 0x8000_0008 of 32'h1122_3344 with wstrb=4'b0101 over old 32'hFFFF_FFFF, with W sent 3 cycles before AW -> bresp=00, then a read returns FF22_FF44.
- Read at 0x0000_0000 with arlen=1 -> two beats with rresp=11 and rdata=0; write to 0x9000_0000 -> bresp=11 and memory unchanged.
- arsize=3'b001, arlen=0 -> one beat with rresp=10, rlast=1.
- Reset asserted during R_DATA beat 2 of an arlen=7 burst, with a concurrent write in W_LAT -> next cycle rvalid=0, bvalid=0, arready=1, awready=1; the target word of the dropped write is unchanged.
